// File: rtl/select_3d_array_pipelined.sv
// N-way array selector (whole-array or per-row source) behind a valid/ready handshake.
// A main register plus one skid register keep 1 beat/cycle with in_ready registered.
module select_3d_array_pipelined #(
   parameter int BIT_WIDTH   = 4,
   parameter int ROWS        = 8,
   parameter int COLS        = 8,
   parameter int NUM_SOURCES = 4,
   localparam int SEL_W      = (NUM_SOURCES > 2) ? $clog2(NUM_SOURCES) : 1
) (
   input  logic                                                     clk,
   input  logic                                                     rst_n,
   input  logic [NUM_SOURCES-1:0][ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] in_arrays,
   input  logic [SEL_W-1:0]                                         sel,
   input  logic [ROWS-1:0][SEL_W-1:0]                               row_sel,
   input  logic                                                     row_mode,
   input  logic                                                     in_valid,
   output logic                                                     in_ready,
   output logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0]                 result,
   output logic                                                     out_valid,
   input  logic                                                     out_ready
);

   typedef logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] arr_t;
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t           state_q, state_d;
   arr_t             main_q, main_d;
   arr_t             skid_q, skid_d;
   logic             in_ready_q;
   arr_t             sel_arr;
   logic [SEL_W-1:0] idx;
   logic             accept, deliver;

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign result    = main_q;
   assign accept    = in_valid && in_ready_q;
   assign deliver   = out_valid && out_ready;

   // Out-of-range source indices produce an all-zero row rather than an error.
   always_comb begin
      sel_arr = '0;
      idx     = '0;
      for (int r = 0; r < ROWS; r++) begin
         idx = row_mode ? row_sel[r] : sel;
         if (int'(idx) < NUM_SOURCES) begin
            sel_arr[r] = in_arrays[idx][r];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               main_d  = sel_arr;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && deliver) begin
               main_d = sel_arr;
            end else if (accept) begin
               skid_d  = sel_arr;
               state_d = FULL;
            end else if (deliver) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (deliver) begin
               main_d  = skid_q;
               skid_d  = '0;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != FULL);
      end
   end

endmodule
